// File: rtl/res_mem_arbiter.sv
// res_mem_arbiter
//   Shares the single-port 16K x 8 result RAM between two requesters:
//   requester 0 is the distance-transform engine, and requester 1 is host
//   readback/preload.
//   - Fixed priority goes to requester 0.
//   - Requester 1 gets priority for one arbitration after STARVE_MAX
//     consecutive denied cycles.
//   - An owner may lock the RAM for read-modify-write windows of at most
//     LOCK_MAX cycles. The lock is then force-released and lock_err is set.
//   - Memory commands are registered. Read data is routed to the requester
//     that issued the read.
//
// Ports
//   clk, reset                : rising-edge clock, async active-high reset
//   rK_req/lock/we/addr/wdata : requester K transaction (K = 0, 1)
//   rK_gnt                    : combinational accept for requester K
//   rK_rvalid/rdata           : read return for requester K
//   mem_rd/wr/addr/do         : registered RAM command
//   mem_di                    : RAM read data, valid the cycle after mem_rd
//   lock_err                  : sticky, set when a lock was force-released
module res_mem_arbiter #(
  parameter int AW         = 14,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 8,
  parameter int LOCK_MAX   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_lock,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_lock,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_do,
  input  logic [DW-1:0] mem_di,
  output logic          lock_err
);

  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam int LCW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t          r_state;
  logic [SCW-1:0]  r_starve_cnt;
  logic [LCW-1:0]  r_lock_cnt;
  logic            r_lock_err;
  logic            r_mem_rd;
  logic            r_mem_wr;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_do;
  logic            r_rd_tag;      // owner of the read currently on the RAM port
  logic            r_r0_rvalid;
  logic            r_r1_rvalid;
  logic [DW-1:0]   r_r0_hold;
  logic [DW-1:0]   r_r1_hold;

  logic            w_starve_flag;
  logic            w_forced;
  logic            w_r0_gnt;
  logic            w_r1_gnt;
  logic            w_acc0;
  logic            w_acc1;
  logic            w_acc;
  logic            w_we;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;

  assign w_starve_flag = (r_starve_cnt == SCW'(STARVE_MAX));
  // A lock that has reached its budget is released this cycle, whatever the owner asks.
  assign w_forced      = (r_state != ST_IDLE) && (r_lock_cnt == LCW'(LOCK_MAX));

  // Grant selection: IDLE priority, lock ownership, and forced release to the non-owner.
  always_comb begin
    w_r0_gnt = 1'b0;
    w_r1_gnt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_starve_flag) begin
          w_r1_gnt = r1_req;
          w_r0_gnt = r0_req & ~r1_req;
        end else begin
          w_r0_gnt = r0_req;
          w_r1_gnt = r1_req & ~r0_req;
        end
      end
      ST_LOCK0: begin
        if (w_forced) begin
          w_r1_gnt = r1_req;
          w_r0_gnt = r0_req & ~r1_req;
        end else begin
          w_r0_gnt = r0_req;
          w_r1_gnt = 1'b0;
        end
      end
      ST_LOCK1: begin
        if (w_forced) begin
          w_r0_gnt = r0_req;
          w_r1_gnt = r1_req & ~r0_req;
        end else begin
          w_r1_gnt = r1_req;
          w_r0_gnt = 1'b0;
        end
      end
      default: begin
        w_r0_gnt = 1'b0;
        w_r1_gnt = 1'b0;
      end
    endcase
  end

  // Grants are suppressed while reset is held so that every output reads 0.
  assign r0_gnt  = w_r0_gnt & ~reset;
  assign r1_gnt  = w_r1_gnt & ~reset;
  assign w_acc0  = r0_req & r0_gnt;
  assign w_acc1  = r1_req & r1_gnt;
  assign w_acc   = w_acc0 | w_acc1;
  assign w_we    = w_acc1 ? r1_we    : r0_we;
  assign w_addr  = w_acc1 ? r1_addr  : r0_addr;
  assign w_wdata = w_acc1 ? r1_wdata : r0_wdata;

  // Lock FSM: ownership, lock budget counter and sticky forced-release flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_lock_cnt <= '0;
      r_lock_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc0 && r0_lock) begin
            r_state    <= ST_LOCK0;
            r_lock_cnt <= LCW'(1);
          end else if (w_acc1 && r1_lock) begin
            r_state    <= ST_LOCK1;
            r_lock_cnt <= LCW'(1);
          end else begin
            r_state    <= ST_IDLE;
            r_lock_cnt <= '0;
          end
        end
        ST_LOCK0, ST_LOCK1: begin
          if (w_forced) begin
            r_lock_err <= 1'b1;
            // The winner of the release cycle may open a fresh lock window.
            if (w_acc0 && r0_lock) begin
              r_state    <= ST_LOCK0;
              r_lock_cnt <= LCW'(1);
            end else if (w_acc1 && r1_lock) begin
              r_state    <= ST_LOCK1;
              r_lock_cnt <= LCW'(1);
            end else begin
              r_state    <= ST_IDLE;
              r_lock_cnt <= '0;
            end
          end else if (r_state == ST_LOCK0) begin
            if ((w_acc0 && !r0_lock) || (!r0_req && !r0_lock)) begin
              r_state    <= ST_IDLE;
              r_lock_cnt <= '0;
            end else begin
              r_lock_cnt <= r_lock_cnt + LCW'(1);
            end
          end else begin
            if ((w_acc1 && !r1_lock) || (!r1_req && !r1_lock)) begin
              r_state    <= ST_IDLE;
              r_lock_cnt <= '0;
            end else begin
              r_lock_cnt <= r_lock_cnt + LCW'(1);
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_lock_cnt <= '0;
        end
      endcase
    end
  end

  // Starvation counter for requester 1; it also counts through requester 0 locks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_acc1) begin
      r_starve_cnt <= '0;
    end else if (r1_req && !r1_gnt && !w_starve_flag) begin
      r_starve_cnt <= r_starve_cnt + SCW'(1);
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

  // Registered RAM command and read owner tag, one cycle after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_do   <= '0;
      r_rd_tag   <= 1'b0;
    end else begin
      r_mem_rd <= w_acc & ~w_we;
      r_mem_wr <= w_acc & w_we;
      if (w_acc) begin
        r_mem_addr <= w_addr;
      end else begin
        r_mem_addr <= r_mem_addr;
      end
      if (w_acc && w_we) begin
        r_mem_do <= w_wdata;
      end else begin
        r_mem_do <= r_mem_do;
      end
      if (w_acc && !w_we) begin
        r_rd_tag <= w_acc1;
      end else begin
        r_rd_tag <= r_rd_tag;
      end
    end
  end

  // Read return: the tag travels with mem_rd, so interleaved reads keep issue order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_r0_rvalid <= 1'b0;
      r_r1_rvalid <= 1'b0;
      r_r0_hold   <= '0;
      r_r1_hold   <= '0;
    end else begin
      r_r0_rvalid <= r_mem_rd & ~r_rd_tag;
      r_r1_rvalid <= r_mem_rd & r_rd_tag;
      if (r_r0_rvalid) begin
        r_r0_hold <= mem_di;
      end else begin
        r_r0_hold <= r_r0_hold;
      end
      if (r_r1_rvalid) begin
        r_r1_hold <= mem_di;
      end else begin
        r_r1_hold <= r_r1_hold;
      end
    end
  end

  // RAM data is valid in the rvalid cycle itself, so it is passed straight through.
  assign r0_rdata  = r_r0_rvalid ? mem_di : r_r0_hold;
  assign r1_rdata  = r_r1_rvalid ? mem_di : r_r1_hold;
  assign r0_rvalid = r_r0_rvalid;
  assign r1_rvalid = r_r1_rvalid;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_do    = r_mem_do;
  assign lock_err  = r_lock_err;

endmodule

// File: tb/tb_res_mem_arbiter.sv
module tb_res_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_lock, r0_we;
  logic [13:0] r0_addr;
  logic [7:0]  r0_wdata;
  logic        r0_gnt, r0_rvalid;
  logic [7:0]  r0_rdata;
  logic        r1_req, r1_lock, r1_we;
  logic [13:0] r1_addr;
  logic [7:0]  r1_wdata;
  logic        r1_gnt, r1_rvalid;
  logic [7:0]  r1_rdata;
  logic        mem_rd, mem_wr;
  logic [13:0] mem_addr;
  logic [7:0]  mem_do;
  logic [7:0]  mem_di;
  logic        lock_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] tb_mem [0:16383];

  res_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_lock(r0_lock), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_lock(r1_lock), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_do(mem_do), .mem_di(mem_di),
    .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM: read data appears the cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_wr) tb_mem[mem_addr] <= mem_do;
    if (mem_rd) mem_di <= tb_mem[mem_addr];
  end

  initial begin
    for (int i = 0; i < 16384; i++) tb_mem[i] = 8'(i) ^ 8'hA5;
    mem_di = 8'h00;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    r0_req = 1'b0; r0_lock = 1'b0; r0_we = 1'b0; r0_addr = 14'd0; r0_wdata = 8'd0;
    r1_req = 1'b0; r1_lock = 1'b0; r1_we = 1'b0; r1_addr = 14'd0; r1_wdata = 8'd0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    logic [44:0] outs;
    clear_inputs();
    reset = 1'b1;
    step();
    r0_req = 1'b1;
    r1_req = 1'b1;
    #1;
    outs = {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
            mem_rd, mem_wr, mem_addr, mem_do, lock_err};
    total++;
    if (outs !== 45'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", outs);
    end
    do_reset();
  endtask

  task automatic test_starvation;
    logic exp1;
    do_reset();
    r0_req = 1'b1; r0_addr = 14'd129;
    r1_req = 1'b1; r1_addr = 14'd200;
    for (int i = 1; i <= 12; i++) begin
      #1;
      exp1 = (i == 9);
      total++;
      if (r0_gnt !== !exp1 || r1_gnt !== exp1) begin
        bad++;
        $display("FAIL starve_gnt cycle=%0d got r0=%b r1=%b want r0=%b r1=%b",
                 i, r0_gnt, r1_gnt, !exp1, exp1);
      end
      step();
      total++;
      if (mem_rd !== 1'b1 || mem_addr !== (exp1 ? 14'd200 : 14'd129)) begin
        bad++;
        $display("FAIL starve_cmd cycle=%0d got rd=%b addr=%0d want rd=1 addr=%0d",
                 i, mem_rd, mem_addr, exp1 ? 200 : 129);
      end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_write_read;
    logic [13:0] va [3];
    logic [7:0]  vd [3];
    va[0] = 14'd300;   vd[0] = 8'd5;
    va[1] = 14'd16383; vd[1] = 8'h3C;
    va[2] = 14'd0;     vd[2] = 8'hFF;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      r0_req = 1'b1; r0_we = 1'b1; r0_addr = va[k]; r0_wdata = vd[k];
      #1;
      total++;
      if (r0_gnt !== 1'b1) begin
        bad++;
        $display("FAIL wr_gnt k=%0d got=%b want=1", k, r0_gnt);
      end
      step();
      total++;
      if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== va[k] || mem_do !== vd[k]) begin
        bad++;
        $display("FAIL wr_cmd k=%0d got wr=%b rd=%b addr=%0d do=%h want wr=1 rd=0 addr=%0d do=%h",
                 k, mem_wr, mem_rd, mem_addr, mem_do, va[k], vd[k]);
      end
      r0_we = 1'b0;
      step();
      r0_req = 1'b0;
      total++;
      if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || r0_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL rd_cmd k=%0d got rd=%b wr=%b rvalid=%b want 1 0 0", k, mem_rd, mem_wr, r0_rvalid);
      end
      step();
      total++;
      if (r0_rvalid !== 1'b1 || r0_rdata !== vd[k] || r1_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL rd_data k=%0d got rvalid=%b data=%h r1v=%b want 1 %h 0",
                 k, r0_rvalid, r0_rdata, r1_rvalid, vd[k]);
      end
      step();
      total++;
      if (r0_rvalid !== 1'b0 || r0_rdata !== vd[k] || mem_rd !== 1'b0) begin
        bad++;
        $display("FAIL rd_hold k=%0d got rvalid=%b data=%h rd=%b want 0 %h 0",
                 k, r0_rvalid, r0_rdata, mem_rd, vd[k]);
      end
    end
  endtask

  task automatic test_lock;
    logic [13:0] la [4];
    logic        lw [4];
    logic        ll [4];
    la[0] = 14'd0; la[1] = 14'd1; la[2] = 14'd2; la[3] = 14'd129;
    lw[0] = 1'b0;  lw[1] = 1'b0;  lw[2] = 1'b0;  lw[3] = 1'b1;
    ll[0] = 1'b1;  ll[1] = 1'b1;  ll[2] = 1'b1;  ll[3] = 1'b0;
    do_reset();
    r1_req = 1'b1; r1_addr = 14'd77;
    for (int k = 0; k < 4; k++) begin
      r0_req = 1'b1; r0_addr = la[k]; r0_we = lw[k]; r0_lock = ll[k]; r0_wdata = 8'd9;
      #1;
      total++;
      if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin
        bad++;
        $display("FAIL lock_gnt k=%0d got r0=%b r1=%b want r0=1 r1=0", k, r0_gnt, r1_gnt);
      end
      step();
    end
    r0_req = 1'b0; r0_lock = 1'b0; r0_we = 1'b0;
    #1;
    total++;
    if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0) begin
      bad++;
      $display("FAIL lock_release got r0=%b r1=%b want r0=0 r1=1", r0_gnt, r1_gnt);
    end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_forced_release;
    do_reset();
    r0_req = 1'b1; r0_lock = 1'b1; r0_addr = 14'd40;
    r1_req = 1'b1; r1_addr = 14'd41;
    for (int j = 0; j < 20; j++) begin
      #1;
      total++;
      if (r0_gnt !== (j != 16) || r1_gnt !== (j == 16) || lock_err !== (j >= 17)) begin
        bad++;
        $display("FAIL forced j=%0d got r0=%b r1=%b err=%b want r0=%b r1=%b err=%b",
                 j, r0_gnt, r1_gnt, lock_err, j != 16, j == 16, j >= 17);
      end
      step();
    end
    clear_inputs();
    step();
    step();
    total++;
    if (lock_err !== 1'b1) begin
      bad++;
      $display("FAIL lock_err_sticky got=%b want=1", lock_err);
    end
  endtask

  task automatic test_alternating;
    do_reset();
    r0_req = 1'b1; r0_addr = 14'd10;
    #1;
    total++;
    if (r0_gnt !== 1'b1) begin
      bad++;
      $display("FAIL alt_gnt0 got=%b want=1", r0_gnt);
    end
    step();
    r0_req = 1'b0;
    r1_req = 1'b1; r1_addr = 14'd11;
    #1;
    total++;
    if (r1_gnt !== 1'b1) begin
      bad++;
      $display("FAIL alt_gnt1 got=%b want=1", r1_gnt);
    end
    step();
    r1_req = 1'b0;
    total++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== 8'hAF || r1_rvalid !== 1'b0 ||
        mem_rd !== 1'b1 || mem_addr !== 14'd11) begin
      bad++;
      $display("FAIL alt_ret0 got r0v=%b d=%h r1v=%b rd=%b addr=%0d want 1 af 0 1 11",
               r0_rvalid, r0_rdata, r1_rvalid, mem_rd, mem_addr);
    end
    step();
    total++;
    if (r1_rvalid !== 1'b1 || r1_rdata !== 8'hAE || r0_rvalid !== 1'b0 || r0_rdata !== 8'hAF) begin
      bad++;
      $display("FAIL alt_ret1 got r1v=%b d=%h r0v=%b r0d=%h want 1 ae 0 af",
               r1_rvalid, r1_rdata, r0_rvalid, r0_rdata);
    end
    step();
  endtask

  task automatic test_reset_midread;
    logic [44:0] outs;
    do_reset();
    r0_req = 1'b1; r0_lock = 1'b1; r0_addr = 14'd5;
    r1_req = 1'b1; r1_addr = 14'd6;
    for (int j = 0; j < 9; j++) step();
    total++;
    if (mem_rd !== 1'b1) begin
      bad++;
      $display("FAIL mid_rd_issued got=%b want=1", mem_rd);
    end
    reset = 1'b1;
    #1;
    outs = {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
            mem_rd, mem_wr, mem_addr, mem_do, lock_err};
    total++;
    if (outs !== 45'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs got=%h want=0", outs);
    end
    clear_inputs();
    step();
    step();
    reset = 1'b0;
    for (int j = 0; j < 3; j++) begin
      total++;
      if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL mid_no_rvalid j=%0d got r0v=%b r1v=%b want 0 0", j, r0_rvalid, r1_rvalid);
      end
      step();
    end
    r0_req = 1'b1; r1_req = 1'b1;
    #1;
    total++;
    if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin
      bad++;
      $display("FAIL mid_starve_clear got r0=%b r1=%b want 1 0", r0_gnt, r1_gnt);
    end
    r0_req = 1'b0;
    #1;
    total++;
    if (r1_gnt !== 1'b1 || lock_err !== 1'b0) begin
      bad++;
      $display("FAIL mid_lock_clear got r1=%b err=%b want 1 0", r1_gnt, lock_err);
    end
    step();
    clear_inputs();
    step();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_starvation();
    test_write_read();
    test_lock();
    test_forced_release();
    test_alternating();
    test_reset_midread();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
